dbg_xact_queue: RTL and testbench

Queued, self-retrying transaction sequencer that sits between the command controller and the SWD line engine (`swdIF`). It buffers up to 2^DEPTH_LOG2 DP/AP transactions and launches them back-to-back on the engine's go/idle handshake. It retries ACK=WAIT with a programmable µs back-off, watchdogs hung transactions, and returns one result record per command. After the first FAULT, parity error or timeout it returns skip records until the error is cleared.

---
 rtl/dbg_pkg.sv | 32 +++
 rtl/dbg_sync_fifo.sv | 55 +++++
 rtl/dbg_xact_queue.sv | 216 +++++++++++++++++++++
 tb/tb_dbg_xact_queue.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbg_pkg: shared ACK codes, sequencer states and record widths.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dbg_pkg;

  localparam logic [2:0] ACK_OK      = 3'b001;
  localparam logic [2:0] ACK_WAIT    = 3'b010;
  localparam logic [2:0] ACK_FAULT   = 3'b100;
  localparam logic [2:0] ACK_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_POST    = 3'd4
  } seq_state_t;

  // Command record: {addr32[1:0], rnw, apndp, dwrite}
  function automatic int cmd_rec_w(input int data_w);
    return 4 + data_w;
  endfunction

  // Result record: {ack[2:0], perr, skipped, retries, dread}
  function automatic int res_rec_w(input int data_w, input int retry_w);
    return 5 + data_w + retry_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbg_sync_fifo: show-ahead synchronous FIFO, 2^DEPTH_LOG2 entries.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dbg_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // No bypass: a push into an empty FIFO becomes visible on the next cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/dbg_xact_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbg_xact_queue: queued SWD transaction sequencer with WAIT retry,        |
// | watchdog and sticky-error skip. Revision: 1.0                            |
// +--------------------------------------------------------------------------+
module dbg_xact_queue
  import dbg_pkg::*;
#(
  parameter int DEPTH_LOG2     = 3,
  parameter int DATA_W         = 32,
  parameter int RETRY_W        = 8,
  parameter int TICKS_PER_USEC = 50,
  parameter int BACKOFF_W      = 16,
  parameter int WDOG_USEC      = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_addr32,
  input  logic                 cmd_rnw,
  input  logic                 cmd_apndp,
  input  logic [DATA_W-1:0]    cmd_dwrite,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2:0]           res_ack,
  output logic [DATA_W-1:0]    res_dread,
  output logic                 res_perr,
  output logic                 res_skipped,
  output logic [RETRY_W-1:0]   res_retries,
  input  logic [RETRY_W-1:0]   cfg_retry_limit,
  input  logic [BACKOFF_W-1:0] cfg_backoff_usec,
  input  logic                 err_clr,
  output logic                 sticky_err,
  output logic                 busy,
  output logic                 eng_go,
  output logic [1:0]           eng_addr32,
  output logic                 eng_rnw,
  output logic                 eng_apndp,
  output logic [DATA_W-1:0]    eng_dwrite,
  input  logic                 eng_idle,
  input  logic [2:0]           eng_ack,
  input  logic [DATA_W-1:0]    eng_dread,
  input  logic                 eng_perr
);

  localparam int CMD_W      = cmd_rec_w(DATA_W);
  localparam int RES_W      = res_rec_w(DATA_W, RETRY_W);
  localparam int WDOG_TICKS = WDOG_USEC * TICKS_PER_USEC;
  localparam int WDOG_W     = $clog2(WDOG_TICKS + 1);
  localparam int TICK_W     = $clog2(TICKS_PER_USEC + 1);
  localparam logic [WDOG_W-1:0]    WDOG_LOAD = WDOG_W'(WDOG_TICKS - 1);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(TICKS_PER_USEC - 1);
  localparam logic [BACKOFF_W-1:0] USEC_ONE  = BACKOFF_W'(1);

  seq_state_t           state;
  logic                 idle_meta;
  logic                 idle_s;
  logic [RETRY_W-1:0]   retries;
  logic [WDOG_W-1:0]    wdog;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BACKOFF_W-1:0] usec_cnt;

  logic [2:0]           rec_ack;
  logic                 rec_perr;
  logic                 rec_skipped;
  logic [RETRY_W-1:0]   rec_retries;
  logic [DATA_W-1:0]    rec_dread;

  logic [CMD_W-1:0]     cmd_dout;
  logic                 cmd_empty;
  logic                 cmd_full;
  logic [RES_W-1:0]     res_dout;
  logic [RES_W-1:0]     res_out;
  logic                 res_empty;
  logic                 res_full;
  logic                 posting;

  assign posting   = (state == ST_POST);
  assign cmd_ready = !cmd_full;
  assign res_valid = !res_empty;
  assign busy      = (state != ST_IDLE) || !cmd_empty;
  // Result fields read as zero whenever nothing is being presented.
  assign res_out   = res_valid ? res_dout : '0;
  assign {res_ack, res_perr, res_skipped, res_retries, res_dread} = res_out;

  dbg_sync_fifo #(.WIDTH(CMD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   ({cmd_addr32, cmd_rnw, cmd_apndp, cmd_dwrite}),
    .pop   (posting),
    .dout  (cmd_dout),
    .empty (cmd_empty),
    .full  (cmd_full)
  );

  dbg_sync_fifo #(.WIDTH(RES_W), .DEPTH_LOG2(DEPTH_LOG2)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (posting),
    .din   ({rec_ack, rec_perr, rec_skipped, rec_retries, rec_dread}),
    .pop   (res_ready),
    .dout  (res_dout),
    .empty (res_empty),
    .full  (res_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idle_meta   <= 1'b0;
      idle_s      <= 1'b0;
      retries     <= '0;
      wdog        <= '0;
      tick_cnt    <= '0;
      usec_cnt    <= '0;
      sticky_err  <= 1'b0;
      eng_go      <= 1'b0;
      eng_addr32  <= '0;
      eng_rnw     <= 1'b0;
      eng_apndp   <= 1'b0;
      eng_dwrite  <= '0;
      rec_ack     <= '0;
      rec_perr    <= 1'b0;
      rec_skipped <= 1'b0;
      rec_retries <= '0;
      rec_dread   <= '0;
    end else begin
      idle_meta <= eng_idle;
      idle_s    <= idle_meta;
      // A set later in this block overrides this clear.
      if (err_clr) sticky_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!cmd_empty && !res_full) begin
            if (sticky_err) begin
              rec_ack     <= '0;
              rec_perr    <= 1'b0;
              rec_skipped <= 1'b1;
              rec_retries <= '0;
              rec_dread   <= '0;
              state       <= ST_POST;
            end else begin
              {eng_addr32, eng_rnw, eng_apndp, eng_dwrite} <= cmd_dout;
              retries <= '0;
              eng_go  <= 1'b1;
              wdog    <= WDOG_LOAD;
              state   <= ST_LAUNCH;
            end
          end
        end

        ST_LAUNCH, ST_RUN: begin
          if (wdog == '0) begin
            eng_go      <= 1'b0;
            rec_ack     <= ACK_TIMEOUT;
            rec_perr    <= 1'b1;
            rec_skipped <= 1'b0;
            rec_retries <= retries;
            rec_dread   <= '0;
            sticky_err  <= 1'b1;
            state       <= ST_POST;
          end else begin
            wdog <= wdog - 1'b1;
            if (state == ST_LAUNCH) begin
              if (!idle_s) begin
                eng_go <= 1'b0;
                state  <= ST_RUN;
              end
            end else if (idle_s) begin
              // Engine outputs are stable while idle, so sample them now.
              rec_ack     <= eng_ack;
              rec_perr    <= eng_perr;
              rec_skipped <= 1'b0;
              rec_retries <= retries;
              rec_dread   <= eng_rnw ? eng_dread : '0;
              if (eng_ack == ACK_OK && !eng_perr) begin
                state <= ST_POST;
              end else if (eng_ack == ACK_WAIT && retries < cfg_retry_limit) begin
                retries  <= retries + 1'b1;
                usec_cnt <= cfg_backoff_usec;
                tick_cnt <= '0;
                state    <= ST_BACKOFF;
              end else begin
                sticky_err <= 1'b1;
                state      <= ST_POST;
              end
            end
          end
        end

        ST_BACKOFF: begin
          // Fire on the last tick of the last µs so N µs spans exactly N*TICKS_PER_USEC clk.
          if (usec_cnt == '0 || (usec_cnt == USEC_ONE && tick_cnt == TICK_LAST)) begin
            eng_go <= 1'b1;
            wdog   <= WDOG_LOAD;
            state  <= ST_LAUNCH;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            usec_cnt <= usec_cnt - 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_POST: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbg_xact_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dbg_xact_queue: directed bench with engine model and result model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dbg_xact_queue;
  import dbg_pkg::*;

  localparam int DW = 32;
  localparam int RW = 8;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_rnw, cmd_apndp;
  logic [1:0]    cmd_addr32;
  logic [DW-1:0] cmd_dwrite;
  logic          res_valid, res_ready, res_perr, res_skipped;
  logic [2:0]    res_ack;
  logic [DW-1:0] res_dread;
  logic [RW-1:0] res_retries, cfg_retry_limit;
  logic [BW-1:0] cfg_backoff_usec;
  logic          err_clr, sticky_err, busy;
  logic          eng_go, eng_rnw, eng_apndp, eng_idle, eng_perr;
  logic [1:0]    eng_addr32;
  logic [DW-1:0] eng_dwrite, eng_dread;
  logic [2:0]    eng_ack;

  dbg_xact_queue #(
    .DEPTH_LOG2(3), .DATA_W(DW), .RETRY_W(RW), .TICKS_PER_USEC(50),
    .BACKOFF_W(BW), .WDOG_USEC(10)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr32(cmd_addr32),
    .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp), .cmd_dwrite(cmd_dwrite),
    .res_valid(res_valid), .res_ready(res_ready), .res_ack(res_ack),
    .res_dread(res_dread), .res_perr(res_perr), .res_skipped(res_skipped),
    .res_retries(res_retries), .cfg_retry_limit(cfg_retry_limit),
    .cfg_backoff_usec(cfg_backoff_usec), .err_clr(err_clr),
    .sticky_err(sticky_err), .busy(busy), .eng_go(eng_go),
    .eng_addr32(eng_addr32), .eng_rnw(eng_rnw), .eng_apndp(eng_apndp),
    .eng_dwrite(eng_dwrite), .eng_idle(eng_idle), .eng_ack(eng_ack),
    .eng_dread(eng_dread), .eng_perr(eng_perr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    ack;
    logic [DW-1:0] data;
    logic          perr;
    logic          hang;
  } resp_t;

  typedef struct packed {
    logic [2:0]    ack;
    logic          perr;
    logic          skipped;
    logic [RW-1:0] retries;
    logic [DW-1:0] dread;
  } rec_t;

  resp_t eng_q[$];
  resp_t mdl_q[$];
  rec_t  exp_q[$];
  rec_t  got_q[$];
  int    got_pop[$];
  int    go_rise[$];
  int    go_fall[$];
  int    idle_rise[$];
  int    rv_rise[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    push_edge = 0;
  int    eng_delay = 3;
  bit    m_sticky = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic resp_t default_resp();
    resp_t p;
    p.ack = ACK_OK; p.data = '0; p.perr = 1'b0; p.hang = 1'b0;
    return p;
  endfunction

  task automatic add_resp(input logic [2:0] a, input logic [DW-1:0] d, input bit pe, input bit hg);
    resp_t p;
    p.ack = a; p.data = d; p.perr = pe; p.hang = hg;
    eng_q.push_back(p);
    mdl_q.push_back(p);
  endtask

  // Outcome of one command from the retry / error rules, given the scripted engine replies.
  task automatic expect_cmd(input bit rnw);
    rec_t  r;
    resp_t p;
    int    tries = 0;
    bit    done = 1'b0;
    r = '0;
    if (m_sticky) begin
      r.skipped = 1'b1;
      exp_q.push_back(r);
      return;
    end
    while (!done) begin
      p = (mdl_q.size() == 0) ? default_resp() : mdl_q.pop_front();
      if (p.hang) begin
        r.ack = ACK_TIMEOUT; r.perr = 1'b1; r.dread = '0; m_sticky = 1'b1; done = 1'b1;
      end else if (p.ack == ACK_OK && !p.perr) begin
        r.ack = p.ack; r.perr = 1'b0; r.dread = rnw ? p.data : '0; done = 1'b1;
      end else if (p.ack == ACK_WAIT && tries < int'(cfg_retry_limit)) begin
        tries++;
      end else begin
        r.ack = p.ack; r.perr = p.perr; r.dread = rnw ? p.data : '0; m_sticky = 1'b1; done = 1'b1;
      end
    end
    r.retries = RW'(tries);
    exp_q.push_back(r);
  endtask

  task automatic push_cmd(input logic [1:0] a, input bit rnw, input bit ap, input logic [DW-1:0] d);
    int n = 0;
    expect_cmd(rnw);
    cmd_valid = 1'b1; cmd_addr32 = a; cmd_rnw = rnw; cmd_apndp = ap; cmd_dwrite = d;
    while (!cmd_ready && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL push_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
    end
    tick();
    push_edge = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin tick(); n++; end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_drain: %0d results outstanding busy=%0b, required 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m_sticky = 1'b0;
  endtask

  // Engine: one scripted reply per eng_go pulse.
  initial begin
    resp_t p;
    int n;
    eng_idle = 1'b1; eng_ack = '0; eng_dread = '0; eng_perr = 1'b0;
    forever begin
      tick();
      if (!rst && eng_go) begin
        p = (eng_q.size() == 0) ? default_resp() : eng_q.pop_front();
        if (!p.hang) eng_idle = 1'b0;
        n = 0;
        while (eng_go && n < 2000) begin tick(); n++; end
        if (!p.hang) begin
          n = 0;
          while (n < eng_delay && !rst) begin tick(); n++; end
          eng_ack = p.ack; eng_dread = p.data; eng_perr = p.perr;
          eng_idle = 1'b1;
          idle_rise.push_back(cyc);
        end
      end
    end
  end

  // Compare and edge-monitor process, sampled on the falling edge.
  initial begin
    bit   prev_go = 1'b0;
    bit   prev_rv = 1'b0;
    rec_t got, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_go = 1'b0; prev_rv = 1'b0;
      end else begin
        if (eng_go && !prev_go) go_rise.push_back(cyc);
        if (!eng_go && prev_go) go_fall.push_back(cyc);
        if (res_valid && !prev_rv) rv_rise.push_back(cyc);
        prev_go = eng_go; prev_rv = res_valid;
        got = {res_ack, res_perr, res_skipped, res_retries, res_dread};
        if (res_valid && res_ready) begin
          got_q.push_back(got);
          got_pop.push_back(cyc + 1);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL result_extra: got %h, required no result", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL result_record: got %h expected %h", got, e);
            end
          end
        end
        if (!res_valid) begin
          total++;
          if (got !== '0) begin
            bad++;
            $display("FAIL res_idle_zero: got %h expected 0", got);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int g0, i0, r0, v0, f0, n;
    cmd_valid = 0; cmd_addr32 = 0; cmd_rnw = 0; cmd_apndp = 0; cmd_dwrite = 0;
    res_ready = 1; cfg_retry_limit = 0; cfg_backoff_usec = 0; err_clr = 0; rst = 1;
    repeat (3) tick();
    check("rst_eng_go", eng_go, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sticky", sticky_err, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_eng_fields", {eng_addr32, eng_rnw, eng_apndp, eng_dwrite}, 0);
    rst = 0;
    tick();

    // DP read, OK
    g0 = go_rise.size(); i0 = idle_rise.size(); r0 = got_q.size(); v0 = rv_rise.size();
    add_resp(ACK_OK, 32'h2BA01477, 0, 0);
    push_cmd(2'b00, 1, 0, 32'h0);
    drain("t1", 1000);
    check("t1_go_latency", go_rise[g0] - push_edge, 1);
    check("t1_res_latency", rv_rise[v0] - idle_rise[i0], 4);
    check("t1_ack", got_q[r0].ack, 3'b001);
    check("t1_dread", got_q[r0].dread, 32'h2BA01477);
    check("t1_retries", got_q[r0].retries, 0);
    check("t1_sticky", sticky_err, 0);
    check("t1_eng_fields", {eng_addr32, eng_rnw, eng_apndp}, 4'b0010);

    // WAIT, WAIT, OK with a 2 µs back-off
    cfg_retry_limit = 3; cfg_backoff_usec = 2;
    g0 = go_rise.size(); i0 = idle_rise.size(); r0 = got_q.size();
    add_resp(ACK_WAIT, 32'h0, 0, 0);
    add_resp(ACK_WAIT, 32'h0, 0, 0);
    add_resp(ACK_OK, 32'hCAFE0001, 0, 0);
    push_cmd(2'b10, 1, 1, 32'h0);
    drain("t2", 2000);
    check("t2_go_count", go_rise.size() - g0, 3);
    check("t2_backoff1", go_rise[g0+1] - idle_rise[i0], 103);
    check("t2_backoff2", go_rise[g0+2] - idle_rise[i0+1], 103);
    check("t2_retries", got_q[r0].retries, 2);
    check("t2_ack", got_q[r0].ack, 3'b001);
    check("t2_dread", got_q[r0].dread, 32'hCAFE0001);
    check("t2_eng_fields", {eng_addr32, eng_rnw, eng_apndp}, 4'b1011);

    // WAIT forever, limit 1, zero back-off
    cfg_retry_limit = 1; cfg_backoff_usec = 0;
    g0 = go_rise.size(); i0 = idle_rise.size(); r0 = got_q.size();
    add_resp(ACK_WAIT, 32'h0, 0, 0);
    add_resp(ACK_WAIT, 32'h0, 0, 0);
    push_cmd(2'b01, 0, 0, 32'h55);
    drain("t3", 1000);
    check("t3_go_count", go_rise.size() - g0, 2);
    check("t3_reissue_gap", go_rise[g0+1] - idle_rise[i0], 4);
    check("t3_ack", got_q[r0].ack, 3'b010);
    check("t3_retries", got_q[r0].retries, 1);
    check("t3_sticky", sticky_err, 1);
    clear_err();
    check("t3_sticky_clr", sticky_err, 0);

    // Four writes, second FAULTs
    g0 = go_rise.size(); r0 = got_q.size();
    add_resp(ACK_OK, 32'h0, 0, 0);
    add_resp(ACK_FAULT, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) push_cmd(2'(i), 0, 1, 32'hA0 + i);
    drain("t4", 2000);
    check("t4_go_count", go_rise.size() - g0, 2);
    check("t4_acks", {got_q[r0].ack, got_q[r0+1].ack, got_q[r0+2].ack, got_q[r0+3].ack}, 12'b001_100_000_000);
    check("t4_skips", {got_q[r0].skipped, got_q[r0+1].skipped, got_q[r0+2].skipped, got_q[r0+3].skipped}, 4'b0011);
    check("t4_skip_gap1", got_pop[r0+2] - got_pop[r0+1], 2);
    check("t4_skip_gap2", got_pop[r0+3] - got_pop[r0+2], 2);
    check("t4_last_dwrite", eng_dwrite, 32'hA1);
    check("t4_sticky", sticky_err, 1);
    clear_err();
    add_resp(ACK_OK, 32'h0, 0, 0);
    push_cmd(2'b11, 0, 1, 32'hA4);
    drain("t4b", 1000);
    check("t4_fifth_go", go_rise.size() - g0, 3);
    check("t4_fifth_ack", {got_q[r0+4].ack, got_q[r0+4].skipped}, 4'b0010);
    check("t4_fifth_dwrite", eng_dwrite, 32'hA4);

    // Hung engine: watchdog
    g0 = go_rise.size(); f0 = go_fall.size(); r0 = got_q.size();
    add_resp(3'b000, 32'h0, 0, 1);
    push_cmd(2'b00, 1, 0, 32'h0);
    drain("t5", 1500);
    check("t5_wdog_len", go_fall[f0] - go_rise[g0], 500);
    check("t5_ack", got_q[r0].ack, 3'b111);
    check("t5_perr", got_q[r0].perr, 1);
    check("t5_sticky", sticky_err, 1);
    clear_err();

    // Back-pressure: 8 held results stall the sequencer
    res_ready = 0;
    g0 = go_rise.size(); r0 = got_q.size();
    for (int i = 0; i < 9; i++) add_resp(ACK_OK, 32'h1000 + i, 0, 0);
    for (int i = 0; i < 8; i++) push_cmd(2'(i), 1, 1, 32'h0);
    check("t6_cmd_full", cmd_ready, 0);
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    check("t6_idle_reached", n < 3000, 1);
    push_cmd(2'b00, 1, 1, 32'h0);
    repeat (60) tick();
    check("t6_stall_go", go_rise.size() - g0, 8);
    check("t6_stall_busy", busy, 1);
    check("t6_stall_pops", got_q.size() - r0, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    res_ready = 1;
    drain("t6", 2000);
    check("t6_go_total", go_rise.size() - g0, 9);
    check("t6_res_total", got_q.size() - r0, 9);
    check("t6_first", got_q[r0].dread, 32'h1000);
    check("t6_ninth", got_q[r0+8].dread, 32'h1008);

    // Reset while RUN
    eng_delay = 100;
    f0 = go_fall.size();
    add_resp(ACK_OK, 32'h0, 0, 0);
    push_cmd(2'b00, 1, 0, 32'h0);
    n = 0;
    while (go_fall.size() == f0 && n < 200) begin tick(); n++; end
    repeat (5) tick();
    rst = 1;
    tick();
    check("t7_eng_go", eng_go, 0);
    check("t7_eng_fields", {eng_addr32, eng_rnw, eng_apndp, eng_dwrite}, 0);
    check("t7_res", {res_valid, res_ack, res_perr, res_skipped, res_retries, res_dread}, 0);
    check("t7_ctrl", {cmd_ready, sticky_err, busy}, 3'b100);
    exp_q.delete();
    tick();
    rst = 0;
    eng_delay = 3;
    repeat (5) tick();
    r0 = got_q.size();
    add_resp(ACK_OK, 32'h77, 0, 0);
    push_cmd(2'b01, 1, 0, 32'h0);
    drain("t7", 1000);
    check("t7_after_reset", got_q[r0].dread, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
